// File: rtl/rv_plic_core_mt.sv
// rv_plic_core_mt: multi-target PLIC core with per-source gateways, queued edge counts and
// deterministic claim arbitration between targets.
module rv_plic_core_mt #(
    parameter int N_SOURCE = 32,
    parameter int N_TARGET = 2,
    parameter int MAX_PRIO = 7,
    parameter int CNT_W    = 3,
    parameter int SRCW     = $clog2(N_SOURCE + 1),
    parameter int PRIOW    = $clog2(MAX_PRIO + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_SOURCE-1:0]          intr_src_i,
    input  logic [N_SOURCE-1:0]          le_i,
    input  logic [N_SOURCE*PRIOW-1:0]    prio_i,
    input  logic [N_TARGET*N_SOURCE-1:0] ie_i,
    input  logic [N_TARGET*PRIOW-1:0]    threshold_i,
    input  logic [N_TARGET-1:0]          claim_req_i,
    output logic [N_TARGET*SRCW-1:0]     claim_id_o,
    input  logic [N_TARGET-1:0]          complete_req_i,
    input  logic [N_TARGET*SRCW-1:0]     complete_id_i,
    output logic [N_TARGET-1:0]          irq_o,
    output logic [N_TARGET*SRCW-1:0]     irq_id_o,
    output logic [N_SOURCE-1:0]          ip_o,
    output logic [N_SOURCE-1:0]          ovf_o
);
    typedef enum logic [1:0] {IDLE, PEND, CLAIMED} gw_e;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    gw_e                state   [N_SOURCE];
    gw_e                state_n [N_SOURCE];
    logic [CNT_W-1:0]   cnt     [N_SOURCE];
    logic [CNT_W-1:0]   cnt_n   [N_SOURCE];
    logic [PRIOW-1:0]   prio    [N_SOURCE];
    logic [N_SOURCE-1:0] src_q, rise, consume, inc, ovf_set, claimed, completed;
    logic [N_TARGET-1:0] irq_n;
    logic [N_TARGET*SRCW-1:0] irq_id_n;
    logic [PRIOW-1:0]   best_p;
    logic [SRCW-1:0]    best_id;

    for (genvar s = 0; s < N_SOURCE; s++) begin : g_prio
        logic [PRIOW-1:0] raw;
        assign raw = prio_i[s*PRIOW +: PRIOW];
        if ((2**PRIOW) - 1 > MAX_PRIO) begin : g_clamp
            assign prio[s] = (raw > PRIOW'(MAX_PRIO)) ? PRIOW'(MAX_PRIO) : raw;
        end else begin : g_pass
            assign prio[s] = raw;
        end
    end

    // Lower target indices are visited first, so they win a shared id.
    always_comb begin
        claimed    = '0;
        completed  = '0;
        claim_id_o = '0;
        for (int t = 0; t < N_TARGET; t++) begin
            for (int s = 0; s < N_SOURCE; s++) begin
                if (claim_req_i[t] && irq_id_o[t*SRCW +: SRCW] == SRCW'(s + 1) &&
                    state[s] == PEND && !claimed[s]) begin
                    claimed[s] = 1'b1;
                    claim_id_o[t*SRCW +: SRCW] = SRCW'(s + 1);
                end
                if (complete_req_i[t] && complete_id_i[t*SRCW +: SRCW] == SRCW'(s + 1) &&
                    state[s] == CLAIMED && ie_i[t*N_SOURCE + s])
                    completed[s] = 1'b1;
            end
        end
    end

    always_comb begin
        rise    = le_i & intr_src_i & ~src_q;
        consume = '0;
        inc     = '0;
        ovf_set = '0;
        ip_o    = '0;
        for (int s = 0; s < N_SOURCE; s++) begin
            ip_o[s]    = state[s] == PEND;
            consume[s] = le_i[s] && state[s] == IDLE && (cnt[s] != '0 || rise[s]);
            inc[s]     = rise[s] && (cnt[s] != CNT_MAX || consume[s]);
            ovf_set[s] = rise[s] && cnt[s] == CNT_MAX && !consume[s];
            cnt_n[s]   = !le_i[s]                  ? '0 :
                         (inc[s] && !consume[s])  ? cnt[s] + 1'b1 :
                         (consume[s] && !inc[s])  ? cnt[s] - 1'b1 : cnt[s];
            state_n[s] = state[s] == IDLE ?
                             ((le_i[s] ? consume[s] : intr_src_i[s]) ? PEND : IDLE) :
                         state[s] == PEND ? (claimed[s] ? CLAIMED : PEND) :
                                            (completed[s] ? IDLE : CLAIMED);
        end
    end

    // Strict '>' while scanning upward keeps the lowest id on a priority tie.
    always_comb begin
        best_p   = '0;
        best_id  = '0;
        irq_n    = '0;
        irq_id_n = '0;
        for (int t = 0; t < N_TARGET; t++) begin
            best_p  = '0;
            best_id = '0;
            for (int s = 0; s < N_SOURCE; s++) begin
                if (state[s] == PEND && ie_i[t*N_SOURCE + s] && prio[s] > best_p) begin
                    best_p  = prio[s];
                    best_id = SRCW'(s + 1);
                end
            end
            irq_id_n[t*SRCW +: SRCW] = best_id;
            irq_n[t] = best_p > threshold_i[t*PRIOW +: PRIOW];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q    <= '0;
            ovf_o    <= '0;
            irq_o    <= '0;
            irq_id_o <= '0;
            for (int s = 0; s < N_SOURCE; s++) begin
                state[s] <= IDLE;
                cnt[s]   <= '0;
            end
        end else begin
            src_q    <= intr_src_i;
            ovf_o    <= ovf_o | ovf_set;
            irq_o    <= irq_n;
            irq_id_o <= irq_id_n;
            for (int s = 0; s < N_SOURCE; s++) begin
                state[s] <= state_n[s];
                cnt[s]   <= cnt_n[s];
            end
        end
    end
endmodule

// File: tb/tb_rv_plic_core_mt.sv
// tb_rv_plic_core_mt: directed self-checking bench for rv_plic_core_mt.
module tb_rv_plic_core_mt;
    localparam int N  = 32;
    localparam int T  = 2;
    localparam int SW = 6;
    localparam int PW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    src, le;
    logic [N*PW-1:0] prio;
    logic [T*N-1:0]  ie;
    logic [T*PW-1:0] thr;
    logic [T-1:0]    claim_req, complete_req;
    logic [T*SW-1:0] claim_id, complete_id, irq_id;
    logic [T-1:0]    irq;
    logic [N-1:0]    ip, ovf;
    int checks = 0;
    int failures = 0;

    rv_plic_core_mt dut (
        .clk_i(clk), .rst_i(rst), .intr_src_i(src), .le_i(le), .prio_i(prio), .ie_i(ie),
        .threshold_i(thr), .claim_req_i(claim_req), .claim_id_o(claim_id),
        .complete_req_i(complete_req), .complete_id_i(complete_id), .irq_o(irq),
        .irq_id_o(irq_id), .ip_o(ip), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic claim(input int t, input int exp);
        claim_req[t] = 1'b1;
        #1;
        chk($sformatf("claim_id_t%0d", t), 64'(claim_id[t*SW +: SW]), 64'(exp));
        step();
        claim_req[t] = 1'b0;
    endtask

    task automatic complete(input int t, input int id);
        complete_req[t] = 1'b1;
        complete_id[t*SW +: SW] = SW'(id);
        step();
        complete_req[t] = 1'b0;
    endtask

    task automatic pulse(input int s);
        src[s] = 1'b1;
        step();
        src[s] = 1'b0;
        step();
    endtask

    task automatic set_prio(input int id, input int p);
        prio[(id-1)*PW +: PW] = PW'(p);
    endtask

    task automatic set_ie(input int t, input int id, input logic v);
        ie[t*N + id - 1] = v;
    endtask

    initial begin
        rst = 1'b1; src = '0; le = '0; prio = '0; ie = '0; thr = '0;
        claim_req = '0; complete_req = '0; complete_id = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset_ip", 64'(ip), 0);
        chk("reset_irq", 64'(irq), 0);
        chk("reset_irq_id", 64'(irq_id), 0);
        chk("reset_ovf", 64'(ovf), 0);
        chk("reset_claim_id", 64'(claim_id), 0);

        // level source 3
        set_prio(3, 2); set_ie(0, 3, 1); thr[0 +: PW] = 3'd1;
        src[2] = 1'b1;
        step();
        chk("lvl_ip_c1", 64'(ip[2]), 1);
        chk("lvl_irq_c1", 64'(irq[0]), 0);
        step();
        chk("lvl_irq_c2", 64'(irq[0]), 1);
        chk("lvl_irq_id_c2", 64'(irq_id[0 +: SW]), 3);
        claim(0, 3);
        chk("lvl_ip_claimed", 64'(ip[2]), 0);
        chk("lvl_irq_id_window", 64'(irq_id[0 +: SW]), 3);
        claim(0, 0);
        chk("lvl_irq_after_claim", 64'(irq[0]), 0);
        complete(0, 3);
        step();
        chk("lvl_repend", 64'(ip[2]), 1);
        src[2] = 1'b0;
        step();
        claim(0, 3);
        complete(0, 3);
        step();
        chk("lvl_idle", 64'(ip[2]), 0);
        set_ie(0, 3, 0);

        // priority and tie-break
        set_prio(5, 4); set_prio(9, 4); set_prio(12, 6);
        set_ie(0, 5, 1); set_ie(0, 9, 1); set_ie(0, 12, 1);
        src[4] = 1'b1; src[8] = 1'b1; src[11] = 1'b1;
        step();
        step();
        chk("arb_best12", 64'(irq_id[0 +: SW]), 12);
        chk("arb_irq", 64'(irq[0]), 1);
        claim(0, 12);
        step();
        chk("arb_tie5", 64'(irq_id[0 +: SW]), 5);
        thr[0 +: PW] = 3'd6;
        step();
        chk("arb_thr_irq", 64'(irq[0]), 0);
        chk("arb_thr_id", 64'(irq_id[0 +: SW]), 5);
        src[4] = 1'b0; src[8] = 1'b0; src[11] = 1'b0;
        set_ie(0, 5, 0); set_ie(0, 9, 0); set_ie(0, 12, 0);
        thr[0 +: PW] = 3'd0;

        // edge queue with overflow on source 20
        le[19] = 1'b1; set_prio(20, 3); set_ie(0, 20, 1);
        pulse(19);
        chk("edge_ip", 64'(ip[19]), 1);
        chk("edge_irq_id", 64'(irq_id[0 +: SW]), 20);
        claim(0, 20);
        for (int i = 0; i < 9; i++) pulse(19);
        chk("edge_ovf", 64'(ovf[19]), 1);
        chk("edge_ip_claimed", 64'(ip[19]), 0);
        for (int i = 0; i < 7; i++) begin
            complete(0, 20);
            step();
            step();
            claim(0, 20);
        end
        complete(0, 20);
        step();
        step();
        step();
        chk("edge_drained_ip", 64'(ip[19]), 0);
        chk("edge_drained_irq", 64'(irq[0]), 0);
        chk("edge_ovf_sticky", 64'(ovf[19]), 1);
        set_ie(0, 20, 0);

        // simultaneous claim of id 7
        set_prio(7, 5); set_ie(0, 7, 1); set_ie(1, 7, 1);
        src[6] = 1'b1;
        step();
        step();
        chk("dual_id_t1", 64'(irq_id[SW +: SW]), 7);
        claim_req = 2'b11;
        #1;
        chk("dual_claim_t0", 64'(claim_id[0 +: SW]), 7);
        chk("dual_claim_t1", 64'(claim_id[SW +: SW]), 0);
        step();
        claim_req = 2'b00;
        chk("dual_ip", 64'(ip[6]), 0);
        step();
        chk("dual_irq_id_after", 64'(irq_id), 0);

        // ignored completes
        set_ie(1, 7, 0); set_ie(0, 20, 1);
        complete(0, 0);
        step();
        chk("cmp_id0", 64'(ip[6]), 0);
        complete(0, 33);
        step();
        chk("cmp_id33", 64'(ip[6]), 0);
        complete(1, 7);
        step();
        chk("cmp_no_ie", 64'(ip[6]), 0);
        complete(0, 20);
        step();
        chk("cmp_idle", 64'(ip[19]), 0);
        complete(0, 7);
        step();
        chk("cmp_valid", 64'(ip[6]), 1);
        src[6] = 1'b0;

        // reset mid-operation
        pulse(19);
        pulse(19);
        pulse(19);
        step();
        chk("rst_pre_id", 64'(irq_id[0 +: SW]), 7);
        claim(0, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ip", 64'(ip), 0);
        chk("rst_irq", 64'(irq), 0);
        chk("rst_irq_id", 64'(irq_id), 0);
        chk("rst_ovf", 64'(ovf), 0);
        for (int i = 0; i < 4; i++) step();
        chk("rst_no_spurious_ip", 64'(ip), 0);
        chk("rst_no_spurious_irq", 64'(irq), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
